// File: rtl/argmax_stage.sv
// argmax_stage: streaming argmax over consecutive vectors of N signed elements.
// Each vector of N accepted elements produces one result on the output port.
// The result holds the index of the first largest element and that element's value.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload stable until that edge.
// s_ready and m_valid depend only on registers and m_ready.
// There is no combinational path from s_valid or data_in to any output.
module argmax_stage #(
   parameter int T  = 16,
   parameter int N  = 7,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [T-1:0]  data_in,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [IW-1:0] out_idx,
   output logic [T-1:0]  out_max
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] r_cnt;
   logic [T-1:0]  r_best_val;
   logic [IW-1:0] r_best_idx;
   logic          r_m_valid;
   logic [IW-1:0] r_out_idx;
   logic [T-1:0]  r_out_max;

   logic          w_first;
   logic          w_last;
   logic          w_s_ready;
   logic          w_accept;
   logic          w_greater;
   logic [T-1:0]  w_win_val;
   logic [IW-1:0] w_win_idx;

   assign w_first   = (r_cnt == '0);
   assign w_last    = (r_cnt == LAST);
   // Only the last element of a vector needs a free result register.
   // The earlier elements only touch the running-best registers.
   assign w_s_ready = !w_last || !r_m_valid || m_ready;
   assign w_accept  = s_valid && w_s_ready;
   assign w_greater = $signed(data_in) > $signed(r_best_val);

   // Winner after this element: the first element seeds the vector.
   // A later element replaces the best only if it is strictly greater, so ties keep the earliest index.
   always_comb begin
      w_win_val = r_best_val;
      w_win_idx = r_best_idx;
      if (w_first) begin
         w_win_val = data_in;
         w_win_idx = '0;
      end else if (w_greater) begin
         w_win_val = data_in;
         w_win_idx = r_cnt;
      end
   end

   // Element counter and running best; both advance only on an accepted element.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_best_val <= '0;
         r_best_idx <= '0;
      end else if (w_accept) begin
         r_best_val <= w_win_val;
         r_best_idx <= w_win_idx;
         r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Result register: a load wins over a same-cycle consume, so no result is dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_m_valid <= 1'b0;
         r_out_idx <= '0;
         r_out_max <= '0;
      end else if (w_accept && w_last) begin
         r_m_valid <= 1'b1;
         r_out_idx <= w_win_idx;
         r_out_max <= w_win_val;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign s_ready = w_s_ready;
   assign m_valid = r_m_valid;
   assign out_idx = r_out_idx;
   assign out_max = r_out_max;

endmodule

// File: doc/argmax_stage.md
# argmax_stage

Streaming argmax stage that sits directly downstream of the network output port. It consumes the network's signed T-bit output stream over a valid/ready handshake and groups the stream into consecutive vectors of N values. For each vector it emits one result: the index of the largest value and that value. The result feeds the classification and scoring logic.

## Interface

Parameters:
- T, default 16: data width in bits, two's complement.
- N, default 7: vector length, equal to the final layer output count; legal range N >= 1.
- IW, default $clog2(N) with a minimum of 1: width of the index output.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- s_valid, input, 1: upstream data_in is valid.
- s_ready, output, 1: stage can accept data_in this cycle.
- data_in, input, T: signed element from the network's data_out.
- m_valid, output, 1: a result is held on out_idx/out_max.
- m_ready, input, 1: downstream accepts the result.
- out_idx, output, IW: index 0..N-1 of the maximum element within the vector.
- out_max, output, T: signed value of that maximum element.

## Operation

- Accept rule: an element is accepted on a rising edge where s_valid && s_ready. A result is consumed on a rising edge where m_valid && m_ready.
- Element counter cnt (0..N-1):
  - Increments on each accepted element.
  - Wraps to 0 after element N-1.
- Running-best registers best_val and best_idx:
  - Element with cnt==0: best_val <= data_in, best_idx <= 0, unconditionally.
  - Element with cnt==k, k>0: replace best only if data_in > best_val (signed, strict).
  - Ties keep the earliest index.
- Last element (cnt==N-1) accepted:
  - out_max/out_idx are loaded with the final winner, which includes the comparison against this element.
  - m_valid <= 1 and cnt <= 0.
  - best_* values are don't-care afterwards, because the next element reinitialises them.
- N==1: every accepted element is its own result, with out_idx=0 and out_max=data_in.
- s_ready = (cnt != N-1) || !m_valid || m_ready.
  - The first N-1 elements of the next vector are accepted while a result is still pending.
  - Only the last element stalls on a full result register.
- m_valid update:
  - Set by a result load.
  - Cleared by consumption when no load occurs in the same cycle.
  - Simultaneous load and consume: m_valid stays 1 and out_* take the new result.
- out_idx/out_max stay stable while m_valid=1 && m_ready=0.
- Comparison is full-width signed. No saturation or rounding is applied; out_max is bit-exact to one input element.
- data_in is ignored whenever s_valid=0, including when it is X.

## Timing

- Reset (reset_n sampled low at a rising edge):
  - cnt=0, m_valid=0, out_idx=0, out_max=0, best_val=0, best_idx=0.
  - s_ready=1 in the first cycle after reset.
- Reset mid-vector discards the partial vector. Reset with a pending result discards that result.
- Latency: the result is visible (m_valid=1) in the cycle after the edge that accepts the last element.
- Throughput: one element per cycle with no bubbles when m_ready is held high. A vector takes N cycles.
- s_ready, m_valid and out_* are registered or depend only on registers and m_ready. There is no combinational path from s_valid or data_in to any output.
- No result is ever dropped or duplicated. Results appear in vector order.

## Test plan

- Tie and ordering: N=7, input 3,-2,9,9,1,0,-5 -> one result, out_idx=2, out_max=9; a second vector 0,0,0,0,0,0,1 -> out_idx=6, out_max=1.
- Extreme values: seven copies of 16'h8000 -> out_idx=0, out_max=16'h8000. Then 16'h7FFF at position 3 with -1 elsewhere -> out_idx=3, out_max=16'h7FFF.
- Backpressure: m_ready=0, send 14 elements.
  - First result is held.
  - Elements 8-13 are accepted.
  - s_ready=0 with cnt=6.
  - Raise m_ready for one cycle -> first result consumed, 14th element accepted that edge, second result valid next cycle.
- Streaming: s_valid=1 and m_ready=1 for 70 cycles of known data -> exactly 10 results, each m_valid pulse one cycle after every 7th acceptance, s_ready never 0.
- Reset mid-operation: accept 4 elements, drive reset_n low for one edge -> m_valid=0, out_*=0. The next 7 elements form a fresh vector with correct result.
- Random handshake: s_valid and m_ready each randomized per cycle as in the network bench, 1000 vectors -> zero mismatches against a golden model, and exactly 1000 results.
